// File: rtl/adc_capture_trigger.sv
// Single-channel capture: programmable-rate sampling, level/slope trigger, circular pre-trigger buffer.
// Optional timeout auto-trigger when ADC_CAPTURE_AUTO_TRIG_EN is defined; force_trig is the force pulse (force is reserved).
module adc_capture_trigger #(
  parameter int DEPTH        = 1024,
  parameter int AW           = 10,
  parameter int PRE          = 256,
  parameter int AUTO_TIMEOUT = 65535
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [7:0][11:0] adc_data,
  input  logic [2:0]       ch_sel,
  input  logic [11:0]      trig_level,
  input  logic             trig_slope,
  input  logic [15:0]      sample_div,
  input  logic             arm,
  input  logic             force_trig,
  output logic             busy,
  output logic             triggered,
  output logic             done,
  output logic             auto_fired,
  input  logic [AW-1:0]    rd_addr,
  output logic [11:0]      rd_data,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_ARMED = 3'd2,
    S_POST  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam int              POST_N    = DEPTH - PRE - 1;
  localparam logic [AW-1:0]   PRE_A     = AW'(PRE);
  localparam logic [AW-1:0]   PRE_LAST  = AW'((PRE > 0) ? PRE - 1 : 0);
  localparam logic [AW-1:0]   POST_LAST = AW'((POST_N > 0) ? POST_N - 1 : 0);

  if (DEPTH != (1 << AW) || PRE < 0 || PRE >= DEPTH || AUTO_TIMEOUT < 1) begin : g_param_check
    $error("adc_capture_trigger: invalid DEPTH/AW/PRE/AUTO_TIMEOUT");
  end

  state_t         state, state_nxt;
  logic [2:0]     ch_sel_l;
  logic [11:0]    trig_level_l;
  logic           trig_slope_l;
  logic [15:0]    sample_div_l;
  logic [15:0]    div_cnt;
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  trig_ptr;
  logic [AW-1:0]  cnt;
  logic [11:0]    prev;
  logic           prev_valid;
  logic           force_pend;
  logic [11:0]    s;
  logic           tick;
  logic           level_hit;
  logic           auto_hit;
  logic           wr_en;
  logic           trig_now;
  logic           cnt_clr;
  logic           cnt_inc;
  logic [AW-1:0]  rd_idx;
  logic [11:0]    mem [DEPTH];

  assign tick = (div_cnt == sample_div_l);
  assign s    = adc_data[ch_sel_l];

  // Slope detection needs a previous sample taken since the last arm.
  assign level_hit = prev_valid &&
                     (trig_slope_l ? (prev > trig_level_l && s <= trig_level_l)
                                   : (prev < trig_level_l && s >= trig_level_l));

  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    trig_now  = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    if (arm) begin
      state_nxt = (PRE == 0) ? S_ARMED : S_FILL;
    end else begin
      case (state)
        S_FILL: if (tick) begin
          wr_en = 1'b1;
          if (cnt == PRE_LAST) begin
            state_nxt = S_ARMED;
            cnt_clr   = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        S_ARMED: if (tick) begin
          wr_en = 1'b1;
          if (level_hit || force_pend || auto_hit) begin
            trig_now  = 1'b1;
            cnt_clr   = 1'b1;
            state_nxt = (POST_N == 0) ? S_DONE : S_POST;
          end
        end
        S_POST: if (tick) begin
          wr_en = 1'b1;
          if (cnt == POST_LAST) state_nxt = S_DONE;
          else                  cnt_inc   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      ch_sel_l     <= '0;
      trig_level_l <= '0;
      trig_slope_l <= 1'b0;
      sample_div_l <= '0;
      div_cnt      <= '0;
      wr_ptr       <= '0;
      trig_ptr     <= '0;
      cnt          <= '0;
      prev         <= '0;
      prev_valid   <= 1'b0;
      force_pend   <= 1'b0;
      triggered    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (arm) begin
        ch_sel_l     <= ch_sel;
        trig_level_l <= trig_level;
        trig_slope_l <= trig_slope;
        sample_div_l <= sample_div;
        div_cnt      <= '0;
        wr_ptr       <= '0;
        cnt          <= '0;
        prev_valid   <= 1'b0;
        force_pend   <= 1'b0;
        triggered    <= 1'b0;
      end else begin
        div_cnt <= tick ? 16'd0 : div_cnt + 16'd1;
        if (tick) begin
          prev       <= s;
          prev_valid <= 1'b1;
        end
        if (wr_en)        wr_ptr <= wr_ptr + AW'(1);
        if (cnt_clr)      cnt    <= '0;
        else if (cnt_inc) cnt    <= cnt + AW'(1);
        if (trig_now) begin
          trig_ptr  <= wr_ptr;
          triggered <= 1'b1;
        end
        // A force only counts while armed; it is consumed by the trigger it causes.
        if (state != S_ARMED || trig_now) force_pend <= 1'b0;
        else if (force_trig)              force_pend <= 1'b1;
      end
    end
  end

`ifdef ADC_CAPTURE_AUTO_TRIG_EN
  logic [31:0] auto_cnt;

  assign auto_hit = (auto_cnt == 32'(AUTO_TIMEOUT - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      auto_cnt   <= '0;
      auto_fired <= 1'b0;
    end else begin
      if (arm || state != S_ARMED) auto_cnt <= '0;
      else if (tick)               auto_cnt <= auto_cnt + 32'd1;
      if (arm)           auto_fired <= 1'b0;
      else if (trig_now) auto_fired <= auto_hit && !level_hit && !force_pend;
    end
  end
`else
  assign auto_hit   = 1'b0;
  assign auto_fired = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr] <= s;
  end

  // Index 0 of the readout is the oldest pre-trigger sample of the frozen frame.
  assign rd_idx = trig_ptr - PRE_A + rd_addr;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) rd_data <= '0;
    else        rd_data <= mem[rd_idx];
  end

  assign busy      = (state == S_FILL) || (state == S_ARMED) || (state == S_POST);
  assign done      = (state == S_DONE);
  assign dbg_state = state;

endmodule

// File: tb/tb_adc_capture_trigger.sv
// Directed bench for adc_capture_trigger: per-cycle vector tables plus readout tables.
module tb_adc_capture_trigger;
  localparam int DEPTH        = 16;
  localparam int AW           = 4;
  localparam int PRE          = 4;
  localparam int AUTO_TIMEOUT = 8;

  logic             clock = 1'b0;
  logic             reset;
  logic [7:0][11:0] adc_data;
  logic [2:0]       ch_sel;
  logic [11:0]      trig_level;
  logic             trig_slope;
  logic [15:0]      sample_div;
  logic             arm;
  logic             force_trig;
  logic             busy;
  logic             triggered;
  logic             done;
  logic             auto_fired;
  logic [AW-1:0]    rd_addr;
  logic [11:0]      rd_data;
  logic [2:0]       dbg_state;

  adc_capture_trigger #(
    .DEPTH(DEPTH), .AW(AW), .PRE(PRE), .AUTO_TIMEOUT(AUTO_TIMEOUT)
  ) dut (
    .clock(clock), .reset(reset), .adc_data(adc_data), .ch_sel(ch_sel),
    .trig_level(trig_level), .trig_slope(trig_slope), .sample_div(sample_div),
    .arm(arm), .force_trig(force_trig), .busy(busy), .triggered(triggered),
    .done(done), .auto_fired(auto_fired), .rd_addr(rd_addr), .rd_data(rd_data),
    .dbg_state(dbg_state)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        arm_i;
    logic        frc_i;
    logic [11:0] ch3_i;
    logic        busy_e;
    logic        trig_e;
    logic        done_e;
    logic        auto_e;
  } vec_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [11:0]   data;
  } rd_t;

  vec_t vecs[256];
  rd_t  rds[64];
  int   n_vec = 0;
  int   n_rd  = 0;
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic a, input logic f, input int v,
                         input logic b, input logic t, input logic d, input logic au);
    vecs[n_vec] = '{a, f, 12'(v), b, t, d, au};
    n_vec++;
  endtask

  task automatic add_rd(input int a, input int d);
    rds[n_rd] = '{AW'(a), 12'(d)};
    n_rd++;
  endtask

  // Entry i drives inputs for one clock edge, then outputs are compared at the next negedge.
  task automatic run_vecs(input string tag, input int first, input int n);
    for (int i = 0; i < n; i++) begin
      vec_t v;
      v = vecs[first + i];
      arm         = v.arm_i;
      force_trig  = v.frc_i;
      adc_data[3] = v.ch3_i;
      @(negedge clock);
      chk($sformatf("%s[%0d].busy", tag, i),       32'(busy),       32'(v.busy_e));
      chk($sformatf("%s[%0d].triggered", tag, i),  32'(triggered),  32'(v.trig_e));
      chk($sformatf("%s[%0d].done", tag, i),       32'(done),       32'(v.done_e));
      chk($sformatf("%s[%0d].auto_fired", tag, i), 32'(auto_fired), 32'(v.auto_e));
    end
    arm        = 1'b0;
    force_trig = 1'b0;
  endtask

  task automatic run_reads(input string tag, input int first, input int n);
    for (int i = 0; i < n; i++) begin
      rd_addr = rds[first + i].addr;
      @(negedge clock);
      chk($sformatf("%s[addr=%0d]", tag, rds[first + i].addr), 32'(rd_data), 32'(rds[first + i].data));
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".busy"},       32'(busy),       32'd0);
    chk({tag, ".triggered"},  32'(triggered),  32'd0);
    chk({tag, ".done"},       32'(done),       32'd0);
    chk({tag, ".auto_fired"}, 32'(auto_fired), 32'd0);
    chk({tag, ".rd_data"},    32'(rd_data),    32'd0);
    chk({tag, ".state"},      32'(dbg_state),  32'd0);
  endtask

  initial begin
    int b1, b2, b3, b5, b6, r1, r2;

    // Rising ramp 0,100,...: samples 100..400 fill, 500 triggers, frame ends at sample 1600.
    b1 = n_vec;
    for (int i = 0; i < 20; i++)
      add_vec(i == 0, 1'b0, (i <= 16) ? 100 * i : 4000, i < 16, i >= 5, i >= 16, 1'b0);
    // Falling ramp 1000,900,... clamped at 0: trigger on sample 400 (7th), frame ends at 18th.
    b2 = n_vec;
    for (int i = 0; i < 20; i++)
      add_vec(i == 0, 1'b0, (i == 0) ? 4095 : ((1100 - 100 * i > 0) ? 1100 - 100 * i : 0),
              i < 18, i >= 7, i >= 18, 1'b0);
    // Flat 200 below level: force in FILL ignored, force in ARMED fires on the next tick.
    b3 = n_vec;
    for (int i = 0; i < 20; i++)
      add_vec(i == 0, (i == 2) || (i == 6), 200, i < 18, i >= 7, i >= 18, 1'b0);
    // sample_div=3: forced trigger, re-arm in POST, then a real rising edge only after a fresh FILL.
    b5 = n_vec;
    for (int i = 0; i < 48; i++)
      add_vec((i == 0) || (i == 22), i == 18,
              (i < 22 || (i >= 39 && i <= 42)) ? 200 : 1000,
              1'b1, (i >= 20 && i < 22) || i >= 46, 1'b0, 1'b0);
    // Flat input auto-trigger on the 8th armed tick, 11 post samples.
    b6 = n_vec;
    for (int i = 0; i < 25; i++)
      add_vec(i == 0, 1'b0, 200, i < 23, i >= 12, i >= 23, i >= 12);

    r1 = n_rd;
    for (int a = 0; a < 16; a++) add_rd(a, 100 * (a + 1));
    r2 = n_rd;
    for (int a = 0; a <= 8; a++) add_rd(a, 800 - 100 * a);
    add_rd(15, 0);

    reset      = 1'b0;
    adc_data   = {8{12'd3000}};
    ch_sel     = 3'd3;
    trig_level = 12'd450;
    trig_slope = 1'b0;
    sample_div = 16'd0;
    arm        = 1'b0;
    force_trig = 1'b0;
    rd_addr    = '0;

    repeat (3) @(negedge clock);
    chk_all_zero("reset");
    reset = 1'b1;
    @(negedge clock);

    run_vecs("rise", b1, 20);
    chk("rise.state_done", 32'(dbg_state), 32'd4);
    run_reads("rise_rd", r1, 16);

    trig_slope = 1'b1;
    run_vecs("fall", b2, 20);
    run_reads("fall_rd", r2, 10);

    trig_slope = 1'b0;
    run_vecs("force", b3, 20);

    run_vecs("pre_rst", b1, 8);
    chk("pre_rst.state_post", 32'(dbg_state), 32'd3);
    #2 reset = 1'b0;
    #1 chk_all_zero("mid_post_reset");
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    run_vecs("after_rst", b1, 20);
    run_reads("after_rst_rd", r1, 16);

    sample_div = 16'd3;
    run_vecs("rearm", b5, 48);
    chk("rearm.state_post", 32'(dbg_state), 32'd3);

`ifdef ADC_CAPTURE_AUTO_TRIG_EN
    sample_div = 16'd0;
    run_vecs("auto", b6, 25);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
